// File: rtl/re_ctrl_pkg.sv
// rtl/re_ctrl_pkg.sv - shared state encoding and counter sizing for the readout controller
package re_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ERASE,
    ST_EXPOSE,
    ST_READ_SEL,
    ST_READ_CONV,
    ST_DONE
  } state_e;

  // Width able to count 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/re_control_multi_if.sv
// rtl/re_control_multi_if.sv - control inputs and pixel-array/ADC outputs of the readout controller
interface re_control_multi_if #(
  parameter int NUM_ROWS = 2,
  parameter int EXP_W    = 5
);

  logic                init;
  logic                exp_inc;
  logic                exp_dec;
  logic                cont;
  logic [NUM_ROWS-1:0] NRE;
  logic                ADC;
  logic                expose;
  logic                erase;
  logic                busy;
  logic                frame_done;
  logic [EXP_W-1:0]    exp_time;

  modport master (
    input  init, exp_inc, exp_dec, cont,
    output NRE, ADC, expose, erase, busy, frame_done, exp_time
  );

  modport slave (
    output init, exp_inc, exp_dec, cont,
    input  NRE, ADC, expose, erase, busy, frame_done, exp_time
  );

endinterface

// File: rtl/exp_time_reg.sv
// rtl/exp_time_reg.sv - saturating up/down exposure-time register
module exp_time_reg #(
  parameter int EXP_W       = 5,
  parameter int EXP_DEFAULT = 4,
  parameter int EXP_MIN     = 2,
  parameter int EXP_MAX     = 30
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [EXP_W-1:0] value
);

  logic [EXP_W-1:0] value_q, value_d;

  // Simultaneous inc and dec cancel out and hold the value.
  always_comb begin
    value_d = value_q;
    if (inc && !dec && (value_q < EXP_W'(EXP_MAX))) begin
      value_d = value_q + 1'b1;
    end else if (dec && !inc && (value_q > EXP_W'(EXP_MIN))) begin
      value_d = value_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value_q <= EXP_W'(EXP_DEFAULT);
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/re_control_multi.sv
// rtl/re_control_multi.sv - erase/expose/row-readout sequencer for an NUM_ROWS pixel array
module re_control_multi
  import re_ctrl_pkg::*;
#(
  parameter int NUM_ROWS     = 2,
  parameter int EXP_W        = 5,
  parameter int EXP_DEFAULT  = 4,
  parameter int EXP_MIN      = 2,
  parameter int EXP_MAX      = 30,
  parameter int ERASE_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset,
  re_control_multi_if.master bus
);

  localparam int ROW_W = cnt_w(NUM_ROWS);
  localparam int ERA_W = cnt_w(ERASE_CYCLES);
  localparam int PH_W  = (EXP_W > ERA_W) ? EXP_W : ERA_W;

  state_e              state_q, state_d;
  logic [PH_W-1:0]     phase_q, phase_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [EXP_W-1:0]    lat_q, lat_d;
  logic [EXP_W-1:0]    exp_time;
  logic [NUM_ROWS-1:0] nre_q, nre_d;
  logic                adc_q, expose_q, erase_q, busy_q, done_q;

  exp_time_reg #(
    .EXP_W      (EXP_W),
    .EXP_DEFAULT(EXP_DEFAULT),
    .EXP_MIN    (EXP_MIN),
    .EXP_MAX    (EXP_MAX)
  ) u_exp_time (
    .clk  (clk),
    .reset(reset),
    .inc  (bus.exp_inc),
    .dec  (bus.exp_dec),
    .value(exp_time)
  );

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    row_d   = row_q;
    lat_d   = lat_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.init) begin
          state_d = ST_ERASE;
          phase_d = '0;
        end
      end
      ST_ERASE: begin
        // Exposure length is frozen here so mid-frame adjustments wait a frame.
        if (phase_q == PH_W'(ERASE_CYCLES - 1)) begin
          state_d = ST_EXPOSE;
          phase_d = '0;
          lat_d   = exp_time;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      ST_EXPOSE: begin
        if (phase_q == PH_W'(lat_q) - 1'b1) begin
          state_d = ST_READ_SEL;
          row_d   = '0;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      ST_READ_SEL: begin
        state_d = ST_READ_CONV;
      end
      ST_READ_CONV: begin
        if (row_q == ROW_W'(NUM_ROWS - 1)) begin
          state_d = ST_DONE;
        end else begin
          row_d   = row_q + 1'b1;
          state_d = ST_READ_SEL;
        end
      end
      ST_DONE: begin
        if (bus.cont) begin
          state_d = ST_ERASE;
          phase_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    nre_d = '1;
    for (int i = 0; i < NUM_ROWS; i++) begin
      if (((state_d == ST_READ_SEL) || (state_d == ST_READ_CONV)) && (row_d == ROW_W'(i))) begin
        nre_d[i] = 1'b0;
      end
    end
  end

  // Outputs decode next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      phase_q  <= '0;
      row_q    <= '0;
      lat_q    <= EXP_W'(EXP_DEFAULT);
      nre_q    <= '1;
      adc_q    <= 1'b0;
      expose_q <= 1'b0;
      erase_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      row_q    <= row_d;
      lat_q    <= lat_d;
      nre_q    <= nre_d;
      adc_q    <= (state_d == ST_READ_CONV);
      expose_q <= (state_d == ST_EXPOSE);
      erase_q  <= (state_d == ST_ERASE);
      busy_q   <= (state_d != ST_IDLE);
      done_q   <= (state_d == ST_DONE);
    end
  end

  assign bus.NRE        = nre_q;
  assign bus.ADC        = adc_q;
  assign bus.expose     = expose_q;
  assign bus.erase      = erase_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;
  assign bus.exp_time   = exp_time;

endmodule

// File: tb/tb_re_control_multi.sv
// tb/tb_re_control_multi.sv - self-checking bench for the readout controller (2-row and 5-row builds)
module tb_re_control_multi;

  localparam int E       = 2;
  localparam int EXP_DEF = 4;
  localparam int EMIN    = 2;
  localparam int EMAX    = 30;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  re_control_multi_if #(.NUM_ROWS(2), .EXP_W(5)) if2 ();
  re_control_multi_if #(.NUM_ROWS(5), .EXP_W(5)) if5 ();

  re_control_multi #(.NUM_ROWS(2)) u_dut2 (.clk(clk), .reset(reset), .bus(if2));
  re_control_multi #(.NUM_ROWS(5)) u_dut5 (.clk(clk), .reset(reset), .bus(if5));

  int checks   = 0;
  int failures = 0;
  int exp_m    = EXP_DEF;

  // Exposure reference for the 2-row build; the 5-row build keeps its inputs low.
  always @(posedge clk or negedge reset) begin
    if (!reset) exp_m = EXP_DEF;
    else if (if2.exp_inc && !if2.exp_dec) exp_m = (exp_m < EMAX) ? exp_m + 1 : EMAX;
    else if (if2.exp_dec && !if2.exp_inc) exp_m = (exp_m > EMIN) ? exp_m - 1 : EMIN;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // flags = {ADC, expose, erase, busy, frame_done}
  task automatic sample(input bit sel, output logic [7:0] nre, output logic [4:0] fl,
                        output logic [4:0] et);
    if (sel) begin
      nre = {3'b111, if5.NRE};
      fl  = {if5.ADC, if5.expose, if5.erase, if5.busy, if5.frame_done};
      et  = if5.exp_time;
    end else begin
      nre = {6'h3f, if2.NRE};
      fl  = {if2.ADC, if2.expose, if2.erase, if2.busy, if2.frame_done};
      et  = if2.exp_time;
    end
  endtask

  task automatic check_idle(input bit sel, input string tag);
    logic [7:0] nre;
    logic [4:0] fl, et;
    sample(sel, nre, fl, et);
    chk({tag, " nre"}, {24'd0, nre}, 32'hff);
    chk({tag, " flags"}, {27'd0, fl}, 32'd0);
    chk({tag, " exp_time"}, {27'd0, et}, sel ? EXP_DEF : exp_m);
  endtask

  // Entered at the sample point of frame cycle 1; leaves at cycle L+1.
  task automatic check_frame(input bit sel, input int inc_start, input int inc_len,
                             input int cont_drop, input bit rnd);
    int n, lat, len, c, rd, r;
    logic [7:0] nre, nre_e;
    logic [4:0] fl, fl_e, et;
    logic adc_e, reading;
    n   = sel ? 5 : 2;
    lat = 0;
    len = 1000;
    c   = 1;
    while (c <= len && c < 200) begin
      if (c == E) begin
        lat = sel ? EXP_DEF : exp_m;
        len = E + lat + 2 * n + 1;
      end
      sample(sel, nre, fl, et);
      rd      = c - E - lat - 1;
      reading = (c > E) && (rd >= 0) && (rd < 2 * n);
      nre_e   = 8'hff;
      adc_e   = 1'b0;
      if (reading) begin
        nre_e[rd / 2] = 1'b0;
        adc_e         = (rd % 2) == 1;
      end
      fl_e = {adc_e, (c > E) && (c <= E + lat), c <= E, 1'b1, c == len};
      chk($sformatf("nre c%0d", c), {24'd0, nre}, {24'd0, nre_e});
      chk($sformatf("flags c%0d", c), {27'd0, fl}, {27'd0, fl_e});
      chk($sformatf("exp_time c%0d", c), {27'd0, et}, sel ? EXP_DEF : exp_m);
      if (rnd) begin
        r           = $urandom_range(0, 7);
        if2.exp_inc = r[0];
        if2.exp_dec = r[1];
        if2.init    = r[2];
      end else begin
        if2.exp_inc = (c >= inc_start) && (c < inc_start + inc_len);
        if2.exp_dec = 1'b0;
      end
      if (c == cont_drop) if2.cont = 1'b0;
      @(negedge clk);
      c++;
    end
    if (c < 200) chk("frame_bound", 32'd0, 32'd0 + (c < 200 ? 0 : 1));
    else chk("frame_bound", 32'd1, 32'd0);
    if2.exp_inc = 1'b0;
    if2.exp_dec = 1'b0;
    if2.init    = 1'b0;
  endtask

  task automatic pulse_init(input bit sel);
    if (sel) if5.init = 1'b1; else if2.init = 1'b1;
    @(negedge clk);
    if5.init = 1'b0;
    if2.init = 1'b0;
  endtask

  initial begin
    logic [7:0] nre;
    logic [4:0] fl, et;
    if2.init = 0; if2.exp_inc = 0; if2.exp_dec = 0; if2.cont = 0;
    if5.init = 0; if5.exp_inc = 0; if5.exp_dec = 0; if5.cont = 0;

    repeat (3) @(negedge clk);
    check_idle(0, "rst2");
    check_idle(1, "rst5");
    reset = 1'b1;
    @(negedge clk);
    check_idle(0, "post_rst");

    pulse_init(0);
    check_frame(0, 0, 0, 0, 0);
    check_idle(0, "after_f1");
    @(negedge clk);
    check_idle(0, "after_f1b");

    pulse_init(1);
    check_frame(1, 0, 0, 0, 0);
    check_idle(1, "after_f5");

    pulse_init(0);
    check_frame(0, 3, 3, 0, 0);
    sample(0, nre, fl, et);
    chk("exp_after_inc", {27'd0, et}, 32'd7);
    pulse_init(0);
    check_frame(0, 0, 0, 0, 0);
    check_idle(0, "after_f7");

    if2.exp_inc = 1'b1;
    repeat (40) @(negedge clk);
    if2.exp_inc = 1'b0;
    sample(0, nre, fl, et);
    chk("sat_max", {27'd0, et}, 32'd30);
    chk("sat_max_model", {27'd0, et}, exp_m);
    if2.exp_dec = 1'b1;
    repeat (40) @(negedge clk);
    sample(0, nre, fl, et);
    chk("sat_min", {27'd0, et}, 32'd2);
    if2.exp_inc = 1'b1;
    repeat (5) @(negedge clk);
    if2.exp_inc = 1'b0;
    if2.exp_dec = 1'b0;
    sample(0, nre, fl, et);
    chk("both_hold", {27'd0, et}, 32'd2);

    if2.cont = 1'b1;
    pulse_init(0);
    check_frame(0, 0, 0, 0, 0);
    check_frame(0, 0, 0, 3, 0);
    check_idle(0, "after_cont");

    for (int k = 0; k < 6; k++) begin
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        check_idle(0, "rnd_gap");
      end
      pulse_init(0);
      check_frame(0, 0, 0, 0, 1);
      check_idle(0, "rnd_after");
    end

    if2.exp_dec = 1'b1;
    repeat (40) @(negedge clk);
    if2.exp_dec = 1'b0;
    pulse_init(0);
    repeat (5) @(negedge clk);
    sample(0, nre, fl, et);
    chk("pre_rst_adc", {27'd0, fl}, 32'b10010);
    chk("pre_rst_nre", {24'd0, nre}, 32'hfe);
    #2 reset = 1'b0;
    #1;
    check_idle(0, "async_rst");
    chk("async_rst_exp", {27'd0, if2.exp_time}, 32'd4);
    repeat (2) begin
      @(negedge clk);
      check_idle(0, "rst_hold");
    end
    reset = 1'b1;
    @(negedge clk);
    check_idle(0, "rst_release");
    pulse_init(0);
    check_frame(0, 0, 0, 0, 0);
    check_idle(0, "final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/re_control_multi.md
Name: re_control_multi

Overview:
- Parametrised successor to the two-row camera readout controller.
- Sequences erase → expose → per-row readout (active-low row enables plus ADC strobe) for NUM_ROWS pixel rows.
- Holds a saturating, user-adjustable exposure time and adds a continuous-capture mode with frame-done/busy status.
- Sits between the user button/control logic and the pixel array plus ADC.

Parameters:
- NUM_ROWS, 2, number of pixel rows (≥1); width of NRE bus.
- EXP_W, 5, exposure counter width in bits.
- EXP_DEFAULT, 4, exposure time (cycles) loaded at reset.
- EXP_MIN, 2, lower saturation bound for exposure time (≥1).
- EXP_MAX, 30, upper saturation bound (≤2^EXP_W−1, ≥EXP_MIN).
- ERASE_CYCLES, 2, cycles erase is held high (≥1).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- init  in  1  start-frame request, sampled in IDLE.
- exp_inc  in  1  +1 exposure per cycle high.
- exp_dec  in  1  −1 exposure per cycle high.
- cont  in  1  continuous mode; sampled at end of each frame.
- NRE  out  NUM_ROWS  active-low row read enables; at most one bit low at any time.
- ADC  out  1  ADC convert strobe.
- expose  out  1  exposure active.
- erase  out  1  pixel erase active.
- busy  out  1  high in any state other than IDLE.
- frame_done  out  1  one-cycle pulse after the last row is read.
- exp_time  out  EXP_W  current exposure setting.

Behaviour:
- Reset (reset=0, async):
  - State returns to IDLE from any state, mid-frame included.
  - NRE all ones; ADC, expose, erase, busy, frame_done all 0.
  - exp_time = EXP_DEFAULT; row and phase counters cleared.
- Outputs are registered and decoded from next-state, so each output is valid in the cycle of its state.
- FSM states: IDLE, ERASE, EXPOSE, READ_SEL, READ_CONV, DONE.
  - IDLE: init=1 at edge k → ERASE from cycle k+1. init in any other state is ignored.
  - ERASE: erase=1 for exactly ERASE_CYCLES cycles → EXPOSE.
  - EXPOSE: expose=1 for exactly exp_lat cycles. exp_lat is a copy of exp_time latched on entry → READ_SEL with row=0.
  - READ_SEL: NRE[row]=0, ADC=0, one cycle → READ_CONV.
  - READ_CONV: NRE[row]=0, ADC=1, one cycle. If row<NUM_ROWS−1: row+1, go to READ_SEL. Otherwise go to DONE.
  - DONE: frame_done=1, busy=1, one cycle. If cont=1 → ERASE (back-to-back frame). Otherwise → IDLE.
- Frame length = ERASE_CYCLES + exp_lat + 2·NUM_ROWS + 1 cycles.
- Exposure register:
  - Updates every cycle in every state.
  - inc only: +1, saturating at EXP_MAX. dec only: −1, saturating at EXP_MIN. Both or neither: hold.
  - A change during EXPOSE does not alter the frame in progress (exp_lat); it takes effect at the next EXPOSE entry.
- Clearing cont mid-frame finishes the current frame, then goes to IDLE.
- Row counter width is clog2(NUM_ROWS), minimum 1.

Decomposition:
- Package re_ctrl_pkg holds:
  - state enumeration;
  - localparam row-counter-width function (clog2 with minimum 1).
- Sub-module exp_time_reg: saturating up/down register.
  - Parameters: EXP_W, EXP_DEFAULT, EXP_MIN, EXP_MAX.
  - Ports: clk, reset, inc, dec, value.
- Top instantiates exp_time_reg plus the FSM, phase counter and row counter.

Test Plan:
- Defaults; reset released, init pulse at edge 0:
  - erase high cycles 1–2;
  - expose high cycles 3–6;
  - NRE=2'b10 cycles 7–8, ADC high cycle 8;
  - NRE=2'b01 cycles 9–10, ADC high cycle 10;
  - frame_done high cycle 11; busy low from cycle 12.
- exp_inc held 40 cycles in IDLE → exp_time saturates at 30. Then exp_dec held 40 cycles → exp_time=2. Then inc and dec high together for 5 cycles → exp_time remains 2.
- exp_inc pulsed 3 cycles during EXPOSE of a frame with exp_time=4:
  - current expose stays 4 cycles;
  - exp_time=7;
  - next frame's expose lasts 7 cycles.
- cont=1, init pulse → frames repeat. ERASE starts the cycle after each frame_done, with no IDLE gap. Drop cont during the second frame → that frame completes, then IDLE and busy=0.
- reset asserted asynchronously mid-READ_CONV (between clock edges):
  - NRE=all ones and ADC=0 immediately;
  - exp_time=4;
  - no frame_done;
  - after release, a fresh init gives a full correct frame.
- NUM_ROWS=5 build, init with exp_time=4:
  - NRE walks 11110→11101→11011→10111→01111, each held 2 cycles;
  - 5 ADC pulses;
  - frame_done at cycle 17;
  - never more than one NRE bit low.
